// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code checker: FSM state encoding,
// digit width, blink pattern selectors and the keypad digit validity rule.
package lock_pkg;

  localparam int   DIGIT_W    = 4;
  localparam logic BLINK_FAIL = 1'b0;
  localparam logic BLINK_OK   = 1'b1;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_CHECK,
    ST_BLINK_BUSY,
    ST_BLINK_DONE,
    ST_OPEN,
    ST_LOCKOUT
  } lock_state_t;

  // The scanner reports 0 for "no key" and codes above 9 for non-digit keys.
  function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] key);
    return (key != '0) && (key <= DIGIT_W'(9));
  endfunction

endpackage

// File: rtl/key_release_detect.sv
// Turns the held-key level from the keypad scanner into a one-cycle release
// strobe, qualified so that only keys 1..9 are reported.
module key_release_detect
  import lock_pkg::*;
(
  input  logic               hwclk,
  input  logic               rst_n,
  input  logic               bstate,
  input  logic [DIGIT_W-1:0] button,
  output logic               rel_valid,
  output logic [DIGIT_W-1:0] rel_digit
);

  logic bstate_reg;

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      bstate_reg <= 1'b0;
    end else begin
      bstate_reg <= bstate;
    end
  end

  // The key code is still on the bus during the cycle the key is let go.
  assign rel_valid = bstate_reg && !bstate && is_valid_digit(button);
  assign rel_digit = button;

endmodule

// File: rtl/code_checker.sv
// Keypad code lock: collects CODE_LEN digits, asks the blinker for a pass/fail
// pattern and opens on a match. Define CODE_CHECKER_LOCKOUT_EN for lockout.
module code_checker
  import lock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd12_000_000
) (
  input  logic               hwclk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] button,
  input  logic               bstate,
  input  logic               done_blinking,
  output logic               start_blinking,
  output logic               blink_type,
  output logic               unlocked,
  output logic               locked_out,
  output logic [2:0]         digit_count
);

  localparam logic [2:0] CODE_LEN_C = 3'(CODE_LEN);

  lock_state_t        state_reg;
  logic [15:0]        entry_reg;
  logic [15:0]        entry_fill;
  logic [2:0]         digit_count_reg;
  logic               start_blinking_reg;
  logic               blink_type_reg;
  logic               unlocked_reg;
  logic [3:0]         nibble_ok;
  logic               code_match;
  logic               rel_valid;
  logic [DIGIT_W-1:0] rel_digit;

  key_release_detect u_release (
    .hwclk     (hwclk),
    .rst_n     (rst_n),
    .bstate    (bstate),
    .button    (button),
    .rel_valid (rel_valid),
    .rel_digit (rel_digit)
  );

  // Digit k of an attempt lands in nibble k counted from the top, so the
  // first CODE_LEN nibbles line up with CODE whatever CODE_LEN is.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
    localparam int HI = 15 - 4 * gi;
    assign entry_fill[HI -: 4] = (digit_count_reg == 3'(gi)) ? rel_digit
                                                              : entry_reg[HI -: 4];
    assign nibble_ok[gi] = (gi >= CODE_LEN) || (entry_reg[HI -: 4] == CODE[HI -: 4]);
  end

  assign code_match = &nibble_ok;

`ifdef CODE_CHECKER_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);

  logic [FAIL_W-1:0] fail_cnt_reg;
  logic [23:0]       timer_reg;
  logic              locked_out_reg;

  assign locked_out = locked_out_reg;
`else
  localparam int unused_lockout_cfg = MAX_FAILS + int'(LOCKOUT_CYCLES);

  assign locked_out = 1'b0;
`endif

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_reg          <= ST_COLLECT;
      entry_reg          <= '0;
      digit_count_reg    <= '0;
      start_blinking_reg <= 1'b0;
      blink_type_reg     <= 1'b0;
      unlocked_reg       <= 1'b0;
`ifdef CODE_CHECKER_LOCKOUT_EN
      fail_cnt_reg       <= '0;
      timer_reg          <= '0;
      locked_out_reg     <= 1'b0;
`endif
    end else begin
      start_blinking_reg <= 1'b0;
      case (state_reg)
        ST_COLLECT: begin
          if (rel_valid) begin
            entry_reg       <= entry_fill;
            digit_count_reg <= digit_count_reg + 3'd1;
            if (digit_count_reg == CODE_LEN_C - 3'd1) begin
              state_reg <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          start_blinking_reg <= 1'b1;
          blink_type_reg     <= code_match ? BLINK_OK : BLINK_FAIL;
          digit_count_reg    <= '0;
`ifdef CODE_CHECKER_LOCKOUT_EN
          if (code_match) begin
            fail_cnt_reg <= '0;
          end else if (fail_cnt_reg != FAIL_MAX) begin
            fail_cnt_reg <= fail_cnt_reg + 1'b1;
          end
`endif
          state_reg <= ST_BLINK_BUSY;
        end

        // The blinker acknowledges by dropping done, then raises it when finished.
        ST_BLINK_BUSY: begin
          if (!done_blinking) begin
            state_reg <= ST_BLINK_DONE;
          end
        end

        ST_BLINK_DONE: begin
          if (done_blinking) begin
            if (blink_type_reg == BLINK_OK) begin
              unlocked_reg <= 1'b1;
              state_reg    <= ST_OPEN;
            end
`ifdef CODE_CHECKER_LOCKOUT_EN
            else if (fail_cnt_reg == FAIL_MAX) begin
              locked_out_reg <= 1'b1;
              timer_reg      <= '0;
              state_reg      <= ST_LOCKOUT;
            end
`endif
            else begin
              state_reg <= ST_COLLECT;
            end
          end
        end

        // Any key closes the lock; that key is not the start of a new attempt.
        ST_OPEN: begin
          if (rel_valid) begin
            unlocked_reg <= 1'b0;
            entry_reg    <= '0;
            state_reg    <= ST_COLLECT;
          end
        end

`ifdef CODE_CHECKER_LOCKOUT_EN
        ST_LOCKOUT: begin
          if (timer_reg == LOCKOUT_CYCLES - 24'd1) begin
            locked_out_reg <= 1'b0;
            fail_cnt_reg   <= '0;
            state_reg      <= ST_COLLECT;
          end else begin
            timer_reg <= timer_reg + 24'd1;
          end
        end
`endif

        default: begin
          state_reg <= ST_COLLECT;
        end
      endcase
    end
  end

  assign start_blinking = start_blinking_reg;
  assign blink_type     = blink_type_reg;
  assign unlocked       = unlocked_reg;
  assign digit_count    = digit_count_reg;

endmodule

// File: tb/tb_code_checker.sv
// Directed bench for code_checker with a cycle-level reference model and a
// small blinker that acknowledges start requests after a delay.
module tb_code_checker;

  localparam int          CODE_LEN  = 4;
  localparam logic [15:0] CODE      = 16'h1234;
  localparam int          MAX_FAILS = 3;
  localparam int          LOCK_LEN  = 100;
`ifdef CODE_CHECKER_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       hwclk = 1'b0;
  logic       rst_n;
  logic [3:0] button;
  logic       bstate;
  logic       done_blinking = 1'b1;
  logic       start_blinking;
  logic       blink_type;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] digit_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  code_checker #(
    .CODE_LEN       (CODE_LEN),
    .CODE           (CODE),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (24'(LOCK_LEN))
  ) dut (
    .hwclk          (hwclk),
    .rst_n          (rst_n),
    .button         (button),
    .bstate         (bstate),
    .done_blinking  (done_blinking),
    .start_blinking (start_blinking),
    .blink_type     (blink_type),
    .unlocked       (unlocked),
    .locked_out     (locked_out),
    .digit_count    (digit_count)
  );

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   q_digits[$];
  bit   check_pending = 0;
  int   blink_phase   = 0;
  int   lock_left     = 0;
  int   fails         = 0;
  bit   prev_b        = 0;
  bit   model_live    = 0;
  logic exp_start = 0, exp_type = 0, exp_unl = 0, exp_lock = 0;
  int   exp_cnt = 0;

  always @(posedge hwclk) begin
    bit rel;
    bit ok;
    logic [15:0] code_v;
    rel    = prev_b && !bstate && (button >= 4'd1) && (button <= 4'd9);
    prev_b = bstate;
    exp_start = 1'b0;
    if (!rst_n) begin
      q_digits.delete();
      check_pending = 0; blink_phase = 0; lock_left = 0; fails = 0; prev_b = 0;
      exp_type = 0; exp_unl = 0; exp_lock = 0; exp_cnt = 0;
      model_live = 1;
    end else if (check_pending) begin
      code_v = CODE;
      ok = 1;
      for (int i = 0; i < CODE_LEN; i++)
        if (q_digits[i] != int'((code_v >> (12 - 4 * i)) & 16'hF)) ok = 0;
      exp_start = 1'b1;
      exp_type  = ok;
      exp_cnt   = 0;
      q_digits.delete();
      if (ok) fails = 0;
      else if (fails < MAX_FAILS) fails++;
      check_pending = 0;
      blink_phase   = 1;
    end else if (blink_phase == 1) begin
      if (!done_blinking) blink_phase = 2;
    end else if (blink_phase == 2) begin
      if (done_blinking) begin
        blink_phase = 0;
        if (exp_type) exp_unl = 1'b1;
        else if (LOCK_EN && fails == MAX_FAILS) begin
          exp_lock  = 1'b1;
          lock_left = LOCK_LEN;
        end
      end
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) begin
        exp_lock = 1'b0;
        fails    = 0;
      end
    end else if (exp_unl) begin
      if (rel) exp_unl = 1'b0;
    end else if (rel) begin
      q_digits.push_back(int'(button));
      exp_cnt++;
      if (exp_cnt == CODE_LEN) check_pending = 1;
    end
  end

  // One compare process: every output against the model on every cycle.
  always @(negedge hwclk) begin
    if (model_live) begin
      chk("model_start_blinking", 32'(start_blinking), 32'(exp_start));
      chk("model_blink_type",     32'(blink_type),     32'(exp_type));
      chk("model_unlocked",       32'(unlocked),       32'(exp_unl));
      chk("model_locked_out",     32'(locked_out),     32'(exp_lock));
      chk("model_digit_count",    32'(digit_count),    32'(exp_cnt));
    end
  end

  // ---------------- blinker: ack after 4 cycles, blink for 8 ----------------
  int bl_delay = 0;
  int bl_len   = 0;
  always @(negedge hwclk) begin
    if (bl_delay > 0) begin
      bl_delay--;
      if (bl_delay == 0) begin
        done_blinking = 1'b0;
        bl_len = 8;
      end
    end else if (bl_len > 0) begin
      bl_len--;
      if (bl_len == 0) done_blinking = 1'b1;
    end else if (start_blinking === 1'b1) begin
      bl_delay = 4;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  // Returns at the falling edge right after the release was sampled.
  task automatic press(input logic [3:0] d);
    button = d;
    bstate = 1'b1;
    tick(2);
    bstate = 1'b0;
    tick(1);
    button = 4'd0;
  endtask

  task automatic press_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) press(4'((c >> (12 - 4 * i)) & 16'hF));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick(1);
    while ((check_pending || blink_phase != 0) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL wait_idle timeout at cycle %0d", cyc);
    end
  endtask

  initial begin
    int t0;
    int n;
    rst_n  = 1'b0;
    bstate = 1'b0;
    button = 4'd0;
    tick(3);
    chk("rst_start_blinking", 32'(start_blinking), 0);
    chk("rst_blink_type",     32'(blink_type), 0);
    chk("rst_unlocked",       32'(unlocked), 0);
    chk("rst_locked_out",     32'(locked_out), 0);
    chk("rst_digit_count",    32'(digit_count), 0);
    rst_n = 1'b1;
    tick(2);

    // Correct code, with start_blinking two cycles after the last release.
    press(1); press(2); press(3);
    chk("cnt_after_3", 32'(digit_count), 3);
    press(4);
    chk("latency_n1_start", 32'(start_blinking), 0);
    chk("cnt_full", 32'(digit_count), 4);
    tick(1);
    chk("latency_n2_start", 32'(start_blinking), 1);
    chk("type_ok", 32'(blink_type), 1);
    wait_idle();
    chk("unlocked_1234", 32'(unlocked), 1);
    press(7);
    chk("open_key7_unlocked", 32'(unlocked), 0);
    chk("open_key7_cnt", 32'(digit_count), 0);

    // Wrong code.
    press_code(16'h1235);
    tick(1);
    chk("type_fail", 32'(blink_type), 0);
    wait_idle();
    chk("fail_cnt_zero", 32'(digit_count), 0);
    chk("fail_locked", 32'(unlocked), 0);

    // Invalid keys, then a key during BLINK_BUSY.
    press(1); press(0); press(11);
    chk("invalid_keys_cnt", 32'(digit_count), 1);
    press(2); press(3); press(9);
    press(5);
    wait_idle();
    chk("busy_key_discarded", 32'(digit_count), 0);

    // Third consecutive failure.
    press_code(16'h9999);
    wait_idle();
    if (LOCK_EN) begin
      chk("lockout_set", 32'(locked_out), 1);
      t0 = cyc;
      press_code(16'h1234);
      chk("lockout_ignores_cnt", 32'(digit_count), 0);
      chk("lockout_ignores_unl", 32'(unlocked), 0);
      n = 0;
      while (locked_out === 1'b1 && n < 300) begin
        tick(1);
        n++;
      end
      chk("lockout_length", 32'(cyc - t0), 32'(LOCK_LEN));
    end else begin
      chk("no_lockout", 32'(locked_out), 0);
    end
    press_code(16'h1234);
    wait_idle();
    chk("unlock_after_fails", 32'(unlocked), 1);
    press(7);

    // Reset in the middle of an attempt.
    press(1); press(2);
    chk("mid_cnt_2", 32'(digit_count), 2);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_cnt", 32'(digit_count), 0);
    rst_n = 1'b1;
    tick(1);
    press_code(16'h1234);
    wait_idle();
    chk("unlock_after_rst", 32'(unlocked), 1);
    press(7);

    // Reset in the middle of a blink: no further pulse, no unlock.
    press_code(16'h9999);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(30);
    chk("blink_rst_cnt", 32'(digit_count), 0);
    chk("blink_rst_unl", 32'(unlocked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/code_checker.md
CODE_CHECKER -- requirements
Module: code_checker

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of digits per entry attempt (1..4).
REQ-002 SHALL have parameter CODE, default 16'h1234, secret code; first digit in [15:12], unused low nibbles ignored.
REQ-003 SHALL have parameter MAX_FAILS, default 3, consecutive failed attempts before lockout.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 24'd12_000_000, lockout duration in hwclk cycles.
REQ-005 SHALL have port hwclk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port button  input  4  key code from the keypad scanner; valid digits 1..9.
REQ-008 SHALL have port bstate  input  1  high while a key is held; a press is consumed on its release.
REQ-009 SHALL have port done_blinking  input  1  high when the blinker is idle.
REQ-010 SHALL have port start_blinking  output  1  one-cycle request to the blinker.
REQ-011 SHALL have port blink_type  output  1  0 = fail pattern, 1 = success pattern; stable from start_blinking until blink completes.
REQ-012 SHALL have port unlocked  output  1  lock open.
REQ-013 SHALL have port locked_out  output  1  lockout active.
REQ-014 SHALL have port digit_count  output  3  digits collected in the current attempt.

Function
REQ-015 SHALL register bstate each cycle; release event = registered 1 and current 0; button sampled in the same cycle.
REQ-016 SHALL ignore release events whose button is 0 or >9, with no state change.
REQ-017 SHALL implement states COLLECT, CHECK, BLINK_BUSY, BLINK_DONE, OPEN, LOCKOUT.
REQ-018 COLLECT: valid release shifts digit into a 16-bit entry register and increments digit_count; when count reaches CODE_LEN, next state CHECK.
REQ-019 CHECK (one cycle): compare the top CODE_LEN nibbles of entry to CODE; pulse start_blinking; blink_type = match; on match clear fail count, else increment it (saturating at MAX_FAILS); clear digit_count; go to BLINK_BUSY.
REQ-020 BLINK_BUSY: wait for done_blinking = 0, then BLINK_DONE; BLINK_DONE: wait for done_blinking = 1.
REQ-021 On leaving BLINK_DONE: match -> OPEN; fail count = MAX_FAILS -> LOCKOUT (when enabled); otherwise -> COLLECT.
REQ-022 OPEN: unlocked = 1; any valid release clears unlocked, clears entry, and returns to COLLECT without counting that digit.
REQ-023 All release events in CHECK, BLINK_BUSY, BLINK_DONE and LOCKOUT SHALL be discarded.
REQ-024 digit_count SHALL never exceed CODE_LEN; entry contents beyond CODE_LEN nibbles are don't-care.
REQ-025 Latency: last-digit release at cycle N -> start_blinking high at cycle N+2.

Reset
REQ-026 With rst_n = 0 at a clock edge: state COLLECT, entry 0, digit_count 0, fail count 0, lockout timer 0, registered bstate 0, and all outputs 0.
REQ-027 Reset mid-attempt or mid-blink SHALL abandon the attempt; no start_blinking pulse is issued afterwards for it.

Configuration
REQ-028 Macro CODE_CHECKER_LOCKOUT_EN defined: LOCKOUT state holds locked_out = 1 for LOCKOUT_CYCLES cycles, then clears the fail count and returns to COLLECT.
REQ-029 Macro undefined: no LOCKOUT state, timer or fail counter; locked_out tied 0; failures always return to COLLECT.

Structure
REQ-030 Shared package lock_pkg SHALL hold the state typedef, DIGIT_W = 4, BLINK_FAIL = 0, and BLINK_OK = 1.
REQ-031 Release edge detection SHALL be a sub-module key_release_detect (inputs hwclk, rst_n, bstate, button; outputs rel_valid, rel_digit).

Verification
REQ-032 Sequence releases of 1, 2, 3, 4 -> start_blinking pulse with blink_type = 1; after the blinker handshake, unlocked = 1.
REQ-033 Sequence releases of 1, 2, 3, 5 -> blink_type = 0; return to COLLECT with digit_count = 0 and unlocked = 0.
REQ-034 Three wrong codes with lockout enabled (LOCKOUT_CYCLES = 100) -> locked_out = 1 for 100 cycles; digits entered during lockout are ignored; afterwards 1, 2, 3, 4 unlocks.
REQ-035 Releases with button 0 and then 11 -> digit_count unchanged; then key 5 pressed during BLINK_BUSY -> discarded.
REQ-036 rst_n low after 2 digits -> next cycle digit_count = 0; a full correct code still unlocks afterwards.
REQ-037 In OPEN, release of key 7 -> unlocked = 0 next cycle and digit_count = 0.
